pucch_descrambler: RTL and testbench
====================================

# pucch_descrambler

Consumes the parallel Gold-sequence bits of the PUCCH receive chain and applies them to a stream of hard-decision bits: out = in XOR c(n), with c(n) = x1(n+1600) XOR x2(n+1600) per TS 38.211 §5.2.1. The block drives the shared `x1_seq_gen` instance through load/enable strobes and reads its word back. It generates x2 internally from a per-block c_init. It sits between the PUCCH demodulator output and the UCI decoder, with valid/ready on both sides.

## Interface
- nGenBit, 8: bits per beat. Range 1..27. Must match the connected `x1_seq_gen`.
- clk  in  1  clock
- rst  in  1  reset: asynchronous, active-high
- i_start  in  1  one-cycle start pulse; sampled only in IDLE
- i_c_init  in  31  x2 initial value, captured with i_start
- i_len  in  16  sequence length in bits, captured with i_start; 0 = start ignored
- o_busy  out  1  high in every state except IDLE
- o_x1_load  out  1  drives `x1_seq_gen.i_load`
- o_x1_en  out  1  drives `x1_seq_gen.i_en`
- i_x1_seq  in  nGenBit  from `x1_seq_gen.o_seq_bit`
- i_valid / o_ready / i_data[nGenBit]  input stream
- o_valid / i_ready / o_data[nGenBit] / o_last  output stream
- o_done  out  1  one-cycle pulse when the final output beat is consumed

## Operation
- Bit order: bit k of a beat pairs with c(n+k), where n is the base index of that beat.
- x2 path mirrors `x1_seq_gen` timing exactly.
  - State: 31-bit LFSR; recurrence x2(n+31) = x2(n+3)^x2(n+2)^x2(n+1)^x2(n).
  - Jump: mask M2 = row 0 of the x2 companion matrix raised to the 1600th power. Each output bit is the parity of (window & M2).
  - Word register c2: on load, c2 takes the parity of the current state and the LFSR takes c_init. On advance, c2 takes parity bits and the LFSR shifts by nGenBit.
- Beat count: beats = ceil(len/nGenBit), held in a 16-bit down-counter beats_left.
- FSM states:
  - IDLE: on i_start && i_len!=0, capture c_init and len, then go to LOAD. Otherwise stay in IDLE.
  - LOAD (1 cycle): o_x1_load=1; x2 LFSR takes c_init. Next state PRIME.
  - PRIME (1 cycle): o_x1_en=1; x2 advances. After this cycle, i_x1_seq and c2 hold c(0..nGenBit-1). Next state RUN.
  - RUN:
    - o_ready = (!o_valid || i_ready).
    - Input accept (i_valid && o_ready) causes, in the same cycle: o_x1_en=1, x2 advance, o_data <= i_data ^ i_x1_seq ^ c2, o_valid<=1, beats_left--.
    - Last beat (beats_left==1): o_last<=1, and bits at index >= (len mod nGenBit) are forced to 0 (no forcing when the remainder is 0). Next state DRAIN.
  - DRAIN: o_ready=0. When o_valid && i_ready: o_valid<=0, o_last<=0, o_done=1, next state IDLE.
- o_x1_en is never asserted outside PRIME and accepted beats, so x1 and x2 stay word-aligned under any backpressure.
- Total o_x1_en pulses per job = beats + 1.
- The output register clears o_valid on consumption when no new beat is accepted in the same cycle.

## Timing
- Reset value of every output is 0: o_busy, o_x1_load, o_x1_en, o_ready, o_valid, o_data, o_last, o_done. State returns to IDLE; LFSR, c2 and counters clear.
- Reset mid-job aborts the job with no o_done. The next start runs a clean LOAD.
- Start sampled at cycle 0:
  - LOAD in cycle 1.
  - PRIME in cycle 2.
  - o_ready may first be high in cycle 3.
- Data latency: 1 cycle from input accept to o_valid.
- Throughput: 1 beat/cycle when i_ready stays high.
- o_done pulses in the cycle the last beat handshakes; o_busy falls in the next cycle.
- i_start while busy is ignored, with no capture and no state disturbance.
- The strobes are combinational from state and handshake. o_x1_load and o_x1_en are never high together.

## Test plan
- nGenBit=8, c_init=0x12345, len=32, i_data=0, i_ready=1:
  - o_data matches the golden c(0..31) model.
  - 4 beats arrive on consecutive cycles starting at cycle 4.
  - o_last is high on beat 4 only, and o_done pulses once.
- len=13, nGenBit=8:
  - 2 beats.
  - Beat 2 bits [7:5] are 0; bits [4:0] equal in ^ c(8..12).
  - o_x1_en pulses exactly 3 times.
- len=64 with a random i_ready (50%) and random i_valid gaps:
  - Output equals the golden model bit-exact.
  - No beat is lost or duplicated.
  - o_x1_en count = 9.
- Involution and start handling, len=100, random data:
  - Descrambling the output again with the same c_init returns the original data.
  - i_start pulsed during RUN is ignored.
  - i_start with i_len=0 leaves o_busy=0.
- Reset asserted after beat 3 of 8:
  - All outputs are 0 the next cycle and no o_done is produced.
  - A fresh job (c_init=1, len=24) then matches the golden model.
- nGenBit=1 and nGenBit=27, len=200:
  - Output is bit-exact against the golden model.
  - Beats = 200 and 8 respectively.

Source files
------------

// File: rtl/pucch_descrambler.sv
// PUCCH hard-bit descrambler: out = in ^ c(n), c = x1(n+1600) ^ x2(n+1600).
// Drives the shared x1 generator through load/enable strobes; x2 is built locally with the same timing.
module pucch_descrambler #(
  parameter int nGenBit = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [30:0]        i_c_init,
  input  logic [15:0]        i_len,
  output logic               o_busy,
  output logic               o_x1_load,
  output logic               o_x1_en,
  input  logic [nGenBit-1:0] i_x1_seq,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [nGenBit-1:0] i_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [nGenBit-1:0] o_data,
  output logic               o_last,
  output logic               o_done
);

  localparam int W = 31 + nGenBit;

  // GF(2) polynomial product modulo the x2 characteristic x^31 + x^3 + x^2 + x + 1.
  function automatic logic [30:0] mulmod(input logic [30:0] a, input logic [30:0] b);
    logic [30:0] acc;
    logic [30:0] t;
    acc = '0;
    t   = a;
    for (int i = 0; i < 31; i++) begin
      if (b[i]) acc = acc ^ t;
      t = {t[29:0], 1'b0} ^ (t[30] ? 31'h0000000F : 31'h0);
    end
    return acc;
  endfunction

  // x^1600 mod p: bit i weights x2(n+i) in x2(n+1600).
  function automatic logic [30:0] jump_mask();
    logic [30:0] r;
    logic [30:0] base;
    logic [10:0] e;
    r    = 31'h1;
    base = 31'h2;
    e    = 11'd1600;
    for (int i = 0; i < 11; i++) begin
      if (e[i]) r = mulmod(r, base);
      base = mulmod(base, base);
    end
    return r;
  endfunction

  localparam logic [30:0] M2 = jump_mask();

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PRIME, S_RUN, S_DRAIN} state_t;

  state_t             state_q, state_d;
  logic [30:0]        c_init_q, c_init_d;
  logic [15:0]        beats_left_q, beats_left_d;
  logic [4:0]         rem_q, rem_d;
  logic [30:0]        lfsr_q, lfsr_d;
  logic [nGenBit-1:0] c2_q, c2_d;
  logic [nGenBit-1:0] data_q, data_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;

  logic [W-1:0]       ext;
  logic [30:0]        lfsr_adv;
  logic [nGenBit-1:0] c2_par;
  logic [nGenBit-1:0] keep;
  logic [16:0]        len_round;
  logic [15:0]        beats_calc;
  logic [4:0]         rem_calc;
  logic               last_beat;

  // Extended x2 window: current state plus the next nGenBit recurrence bits.
  always_comb begin
    ext = '0;
    ext[30:0] = lfsr_q;
    for (int i = 31; i < W; i++) begin
      ext[i] = ext[i-31] ^ ext[i-30] ^ ext[i-29] ^ ext[i-28];
    end
    lfsr_adv = ext[nGenBit +: 31];
    c2_par   = '0;
    for (int k = 0; k < nGenBit; k++) begin
      c2_par[k] = ^(ext[k +: 31] & M2);
    end
  end

  always_comb begin
    len_round  = {1'b0, i_len} + 17'(nGenBit - 1);
    beats_calc = 16'(len_round / 17'(nGenBit));
    rem_calc   = 5'(i_len % 16'(nGenBit));
    keep       = '0;
    for (int k = 0; k < nGenBit; k++) begin
      keep[k] = (rem_q == 5'd0) || (5'(k) < rem_q);
    end
  end

  assign last_beat = (beats_left_q == 16'd1);

  always_comb begin
    state_d      = state_q;
    c_init_d     = c_init_q;
    beats_left_d = beats_left_q;
    rem_d        = rem_q;
    lfsr_d       = lfsr_q;
    c2_d         = c2_q;
    data_d       = data_q;
    valid_d      = valid_q;
    last_d       = last_q;
    o_x1_load    = 1'b0;
    o_x1_en      = 1'b0;
    o_ready      = 1'b0;
    o_done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start && (i_len != 16'd0)) begin
          c_init_d     = i_c_init;
          beats_left_d = beats_calc;
          rem_d        = rem_calc;
          state_d      = S_LOAD;
        end
      end
      S_LOAD: begin
        o_x1_load = 1'b1;
        lfsr_d    = c_init_q;
        c2_d      = c2_par;
        state_d   = S_PRIME;
      end
      S_PRIME: begin
        o_x1_en = 1'b1;
        lfsr_d  = lfsr_adv;
        c2_d    = c2_par;
        state_d = S_RUN;
      end
      S_RUN: begin
        o_ready = !valid_q || i_ready;
        if (i_valid && o_ready) begin
          o_x1_en      = 1'b1;
          lfsr_d       = lfsr_adv;
          c2_d         = c2_par;
          data_d       = (i_data ^ i_x1_seq ^ c2_q) & (last_beat ? keep : '1);
          valid_d      = 1'b1;
          last_d       = last_beat;
          beats_left_d = beats_left_q - 16'd1;
          if (last_beat) state_d = S_DRAIN;
        end else if (valid_q && i_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      end
      S_DRAIN: begin
        if (valid_q && i_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          o_done  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      c_init_q     <= '0;
      beats_left_q <= '0;
      rem_q        <= '0;
      lfsr_q       <= '0;
      c2_q         <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      c_init_q     <= c_init_d;
      beats_left_q <= beats_left_d;
      rem_q        <= rem_d;
      lfsr_q       <= lfsr_d;
      c2_q         <= c2_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
    end
  end

  assign o_busy  = (state_q != S_IDLE);
  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_last  = last_q;

endmodule

// File: tb/tb_pucch_descrambler.sv
// Bench for pucch_descrambler at nGenBit 8, 1 and 27, with a behavioural x1 generator and a Gold-sequence reference.
module tb_pucch_descrambler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [30:0] c_init;
  logic [15:0] len;
  logic        ivalid;
  logic [26:0] idata;
  logic        iready;
  int          sel;
  bit          rnd_ready;

  logic [2:0]  sel_oh, st_g, vl_g;
  logic [2:0]  busy, x1ld, x1en, rdy, ovl, olst, odn;
  logic [7:0]  od8, xw8;
  logic [0:0]  od1, xw1;
  logic [26:0] od27, xw27;

  logic        cur_busy, cur_x1ld, cur_x1en, cur_ready, cur_valid, cur_last, cur_done;
  logic [26:0] cur_data;

  bit          x1g [0:2047];
  bit          x2g [0:2047];
  bit          cg  [0:399];
  logic [26:0] din   [0:255];
  logic [26:0] ref_d [0:255];
  logic [27:0] sbq [$];
  logic [26:0] got [$];
  logic [27:0] mon_e;

  int n_vec = 0, n_err = 0;
  int cyc = 0, st_cyc, first_cyc, last_cyc;
  int en_cnt, done_cnt, out_cnt;
  int pos [3];

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  assign sel_oh = 3'b001 << sel;
  assign st_g   = {3{start}} & sel_oh;
  assign vl_g   = {3{ivalid}} & sel_oh;

  pucch_descrambler #(.nGenBit(8)) u_d8 (
    .clk(clk), .rst(rst), .i_start(st_g[0]), .i_c_init(c_init), .i_len(len),
    .o_busy(busy[0]), .o_x1_load(x1ld[0]), .o_x1_en(x1en[0]), .i_x1_seq(xw8),
    .i_valid(vl_g[0]), .o_ready(rdy[0]), .i_data(idata[7:0]),
    .o_valid(ovl[0]), .i_ready(iready), .o_data(od8), .o_last(olst[0]), .o_done(odn[0]));

  pucch_descrambler #(.nGenBit(1)) u_d1 (
    .clk(clk), .rst(rst), .i_start(st_g[1]), .i_c_init(c_init), .i_len(len),
    .o_busy(busy[1]), .o_x1_load(x1ld[1]), .o_x1_en(x1en[1]), .i_x1_seq(xw1),
    .i_valid(vl_g[1]), .o_ready(rdy[1]), .i_data(idata[0:0]),
    .o_valid(ovl[1]), .i_ready(iready), .o_data(od1), .o_last(olst[1]), .o_done(odn[1]));

  pucch_descrambler #(.nGenBit(27)) u_d27 (
    .clk(clk), .rst(rst), .i_start(st_g[2]), .i_c_init(c_init), .i_len(len),
    .o_busy(busy[2]), .o_x1_load(x1ld[2]), .o_x1_en(x1en[2]), .i_x1_seq(xw27),
    .i_valid(vl_g[2]), .o_ready(rdy[2]), .i_data(idata),
    .o_valid(ovl[2]), .i_ready(iready), .o_data(od27), .o_last(olst[2]), .o_done(odn[2]));

  always_comb begin
    cur_busy  = busy[sel];
    cur_x1ld  = x1ld[sel];
    cur_x1en  = x1en[sel];
    cur_ready = rdy[sel];
    cur_valid = ovl[sel];
    cur_last  = olst[sel];
    cur_done  = odn[sel];
    case (sel)
      0:       cur_data = {19'b0, od8};
      1:       cur_data = {26'b0, od1};
      default: cur_data = od27;
    endcase
  end

  function automatic int nbits(input int k);
    return (k == 0) ? 8 : ((k == 1) ? 1 : 27);
  endfunction

  function automatic logic [26:0] x1word(input int p, input int n);
    logic [26:0] w;
    w = '0;
    for (int k = 0; k < 27; k++) begin
      if (k < n && (1600 + p + k) < 2048) w[k] = x1g[1600 + p + k];
    end
    return w;
  endfunction

  // Shared x1 generator model: load rewinds, each enable registers the next word.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pos[0] <= 0; pos[1] <= 0; pos[2] <= 0;
      xw8 <= '0; xw1 <= '0; xw27 <= '0;
    end else begin
      if (x1ld[0]) pos[0] <= 0;
      else if (x1en[0]) begin xw8 <= 8'(x1word(pos[0], 8)); pos[0] <= pos[0] + 8; end
      if (x1ld[1]) pos[1] <= 0;
      else if (x1en[1]) begin xw1 <= 1'(x1word(pos[1], 1)); pos[1] <= pos[1] + 1; end
      if (x1ld[2]) pos[2] <= 0;
      else if (x1en[2]) begin xw27 <= x1word(pos[2], 27); pos[2] <= pos[2] + 27; end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_vec++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got_v, exp_v, $time);
    end
  endtask

  task automatic gen_c(input logic [30:0] ci);
    for (int i = 0; i < 31; i++) x2g[i] = ci[i];
    for (int i = 31; i < 2048; i++) x2g[i] = x2g[i-31] ^ x2g[i-30] ^ x2g[i-29] ^ x2g[i-28];
    for (int n = 0; n < 400; n++) cg[n] = x1g[n + 1600] ^ x2g[n + 1600];
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    iready = rnd_ready ? 1'($urandom % 2) : 1'b1;
  end

  // Output monitor and scoreboard pop.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (cur_x1en) en_cnt++;
      if (cur_x1ld) chk("ld_en_excl", {31'b0, cur_x1en}, 0);
      if (cur_done) done_cnt++;
      if (cur_valid && iready) begin
        if (sbq.size() == 0) chk("sb_underflow", sbq.size(), 1);
        else begin
          mon_e = sbq.pop_front();
          chk("data", {5'b0, cur_data}, {5'b0, mon_e[26:0]});
          chk("last", {31'b0, cur_last}, {31'b0, mon_e[27]});
        end
        got.push_back(cur_data);
        if (out_cnt == 0) first_cyc = cyc;
        last_cyc = cyc;
        out_cnt++;
      end
    end
  end

  task automatic run_job(input int k, input logic [30:0] ci, input int ln,
                         input bit gaps, input bit rndrdy, input bit midst,
                         input bit invol, input int abort_at, input bit timing);
    int nb, beats, rem, t;
    logic [26:0] cw, m, ex;
    nb    = nbits(k);
    beats = (ln + nb - 1) / nb;
    rem   = ln % nb;
    sel   = k;
    gen_c(ci);
    sbq.delete(); got.delete();
    en_cnt = 0; done_cnt = 0; out_cnt = 0;
    rnd_ready = rndrdy;
    @(posedge clk); #1;
    start = 1'b1; c_init = ci; len = 16'(ln); st_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int b = 0; b < beats; b++) begin
      if (gaps) begin
        repeat ($urandom % 3) begin ivalid = 1'b0; @(posedge clk); #1; end
      end
      ivalid = 1'b1;
      idata  = din[b];
      if (midst && b == 5) begin start = 1'b1; c_init = 31'h7777; len = 16'd9; end
      t = 0;
      do begin @(negedge clk); t++; end while (!cur_ready && t < 500);
      if (!cur_ready) chk("in_timeout", {31'b0, cur_ready}, 1);
      cw = '0;
      for (int kk = 0; kk < nb; kk++) cw[kk] = cg[b * nb + kk];
      m = 27'((28'(1) << nb) - 28'(1));
      if (b == beats - 1 && rem != 0) m = 27'((28'(1) << rem) - 28'(1));
      ex = invol ? (ref_d[b] & m) : ((din[b] ^ cw) & m);
      sbq.push_back({(b == beats - 1), ex});
      @(posedge clk); #1;
      ivalid = 1'b0;
      start  = 1'b0;
      if (abort_at != 0 && b == abort_at - 1) begin
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ctl", {25'b0, cur_busy, cur_x1ld, cur_x1en, cur_ready, cur_valid, cur_last, cur_done}, 0);
        chk("abort_data", {5'b0, cur_data}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        sbq.delete();
        repeat (6) @(negedge clk);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_idle", {31'b0, cur_busy}, 0);
        rnd_ready = 1'b0;
        return;
      end
    end
    t = 0;
    do begin @(negedge clk); t++; end while (!cur_done && t < 2000);
    chk("done_seen", {31'b0, cur_done}, 1);
    @(negedge clk);
    chk("busy_fall", {31'b0, cur_busy}, 0);
    repeat (3) @(negedge clk);
    chk("beats", out_cnt, beats);
    chk("done_cnt", done_cnt, 1);
    chk("x1en_cnt", en_cnt, beats + 1);
    chk("sb_empty", sbq.size(), 0);
    if (timing) begin
      chk("first_lat", first_cyc - st_cyc, 4);
      chk("throughput", last_cyc - first_cyc, beats - 1);
    end
    rnd_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ivalid = 1'b0; idata = '0; c_init = '0; len = '0;
    sel = 0; rnd_ready = 1'b0; iready = 1'b1;
    for (int i = 0; i < 31; i++) x1g[i] = (i == 0);
    for (int i = 31; i < 2048; i++) x1g[i] = x1g[i-31] ^ x1g[i-28];

    repeat (3) @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      sel = k;
      @(negedge clk);
      chk($sformatf("rst_ctl%0d", k),
          {25'b0, cur_busy, cur_x1ld, cur_x1en, cur_ready, cur_valid, cur_last, cur_done}, 0);
      chk($sformatf("rst_data%0d", k), {5'b0, cur_data}, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 256; i++) din[i] = '0;
    run_job(0, 31'h12345, 32, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 256; i++) din[i] = 27'($urandom);
    run_job(0, 31'(($urandom)), 13, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 256; i++) din[i] = 27'($urandom);
    run_job(0, 31'h5A5A5A5, 64, 1, 1, 0, 0, 0, 0);

    for (int i = 0; i < 256; i++) din[i] = 27'($urandom);
    run_job(0, 31'h3C0FFEE, 100, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 256; i++) begin
      ref_d[i] = din[i];
      din[i]   = (i < got.size()) ? got[i] : '0;
    end
    run_job(0, 31'h3C0FFEE, 100, 1, 1, 0, 1, 0, 0);

    @(posedge clk); #1;
    start = 1'b1; len = 16'd0; c_init = 31'h1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("len0_busy_a", {31'b0, cur_busy}, 0);
    @(negedge clk);
    chk("len0_busy_b", {31'b0, cur_busy}, 0);

    for (int i = 0; i < 256; i++) din[i] = 27'($urandom);
    run_job(0, 31'h0BADCAB, 64, 0, 0, 0, 0, 3, 0);
    for (int i = 0; i < 256; i++) din[i] = 27'($urandom);
    run_job(0, 31'h1, 24, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 256; i++) din[i] = 27'($urandom);
    run_job(1, 31'h2468ACE, 200, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) din[i] = 27'($urandom);
    run_job(2, 31'h13579BD, 200, 1, 1, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
